// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg: shared memory-port request/response types and arbiter enums |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_pkg;

  localparam int c_addr_w = 32;
  localparam int c_data_w = 128;

  typedef struct packed {
    logic                Valid;
    logic                Wen;
    logic [c_data_w-1:0] WriteD;
    logic [c_addr_w-1:0] Addr;
  } MInput;

  typedef struct packed {
    logic                Ready;
    logic [c_data_w-1:0] ReadD;
  } MOutput;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
  typedef enum logic {REQ_IC, REQ_DC} req_id_e;

  function automatic logic [1:0] grant_onehot(input req_id_e id);
    return (id == REQ_IC) ? 2'b01 : 2'b10;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_rr_pick: two-way round-robin winner selection (combinational)|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arb_rr_pick
  import mem_pkg::*;
(
  input  logic    ic_valid,
  input  logic    dc_valid,
  input  req_id_e last_owner,
  output logic    gnt_valid,
  output req_id_e winner
);

  always_comb begin
    gnt_valid = ic_valid | dc_valid;
    winner    = REQ_IC;
    if (ic_valid && dc_valid) begin
      // On a tie the requester that did not go last wins.
      winner = (last_owner == REQ_IC) ? REQ_DC : REQ_IC;
    end else if (dc_valid) begin
      winner = REQ_DC;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter: round-robin icache/dcache arbiter for the memory port   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  MInput      ic_req_i,
  output MOutput     ic_resp_o,
  input  MInput      dc_req_i,
  output MOutput     dc_resp_o,
  output MInput      mem_req_o,
  input  MOutput     mem_resp_i,
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  localparam bit               c_wdog_en   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;
  localparam logic [CNT_W-1:0] c_cnt_thres = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e       r_state,   w_state_nxt;
  MInput            r_mem_req, w_mem_req_nxt;
  logic [1:0]       r_grant,   w_grant_nxt;
  req_id_e          r_last,    w_last_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic    w_pick_vld;
  req_id_e w_pick_id;

  mem_arb_rr_pick u_pick (
    .ic_valid   (ic_req_i.Valid),
    .dc_valid   (dc_req_i.Valid),
    .last_owner (r_last),
    .gnt_valid  (w_pick_vld),
    .winner     (w_pick_id)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_mem_req_nxt = r_mem_req;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;

    // Response data is broadcast; only the owner sees Ready.
    ic_resp_o.ReadD = mem_resp_i.ReadD;
    dc_resp_o.ReadD = mem_resp_i.ReadD;
    ic_resp_o.Ready = (r_state == ARB_BUSY) && r_grant[0] && mem_resp_i.Ready;
    dc_resp_o.Ready = (r_state == ARB_BUSY) && r_grant[1] && mem_resp_i.Ready;

    case (r_state)
      ARB_IDLE: begin
        if (w_pick_vld) begin
          w_mem_req_nxt       = (w_pick_id == REQ_IC) ? ic_req_i : dc_req_i;
          w_mem_req_nxt.Valid = 1'b1;
          w_grant_nxt         = grant_onehot(w_pick_id);
          w_last_nxt          = w_pick_id;
          w_cnt_nxt           = '0;
          w_state_nxt         = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (mem_resp_i.Ready) begin
          w_mem_req_nxt = '0;
          w_grant_nxt   = 2'b00;
          w_state_nxt   = ARB_IDLE;
        end else begin
          if (r_cnt != c_cnt_max) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
          // Flag on the edge the count reaches the threshold; Ready in that cycle wins.
          if (c_wdog_en && (r_cnt == c_cnt_thres)) begin
            w_timeout_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_mem_req <= '0;
      r_grant   <= 2'b00;
      r_last    <= REQ_DC;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem_req <= w_mem_req_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign mem_req_o = r_mem_req;
  assign grant_o   = r_grant;
  assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter: directed and randomized self-checking bench          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;
  import mem_pkg::*;

  logic       clk;
  logic       rst;
  MInput      ic_req, dc_req, mem_req;
  MOutput     ic_resp, dc_resp, mem_resp;
  logic [1:0] grant;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ic_req_i   (ic_req),
    .ic_resp_o  (ic_resp),
    .dc_req_i   (dc_req),
    .dc_resp_o  (dc_resp),
    .mem_req_o  (mem_req),
    .mem_resp_i (mem_resp),
    .grant_o    (grant),
    .timeout_o  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ic_req   = '0;
    dc_req   = '0;
    mem_resp = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Random-phase reference model: transaction-level view of who owns memory.
  MInput   p_ic, p_dc, m_exp;
  logic    p_mr, ic_got, dc_got, m_busy;
  req_id_e m_own, m_last;
  int      m_cnt;

  initial begin
    do_reset();
    chk("rst_mem_req", mem_req, '0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_ic_ready", ic_resp.Ready, 1'b0);

    // Single read
    ic_req = '{1'b1, 1'b0, 128'h0, 32'h0000_0100};
    tick();
    chk("t1_valid", mem_req.Valid, 1'b1);
    chk("t1_addr", mem_req.Addr, 32'h100);
    chk("t1_wen", mem_req.Wen, 1'b0);
    chk("t1_grant", grant, 2'b01);
    tick();
    tick();
    mem_resp = '{1'b1, 128'hDEADBEEF_00000000_11111111_22222222};
    #1;
    chk("t1_ic_ready", ic_resp.Ready, 1'b1);
    chk("t1_ic_readd", ic_resp.ReadD, 128'hDEADBEEF_00000000_11111111_22222222);
    chk("t1_dc_ready", dc_resp.Ready, 1'b0);
    tick();
    ic_req.Valid = 1'b0;
    mem_resp     = '0;
    chk("t1_valid_after", mem_req.Valid, 1'b0);
    chk("t1_grant_after", grant, 2'b00);

    // Tie and rotation
    do_reset();
    ic_req = '{1'b1, 1'b0, 128'h0, 32'h40};
    dc_req = '{1'b1, 1'b1, {16{8'hA5}}, 32'h80};
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("t2_grant", grant, (t % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_req", mem_req, (t % 2 == 0) ? ic_req : dc_req);
      mem_resp.Ready = 1'b1;
      #1;
      chk("t2_ic_ready", ic_resp.Ready, (t % 2 == 0) ? 1'b1 : 1'b0);
      chk("t2_dc_ready", dc_resp.Ready, (t % 2 == 0) ? 1'b0 : 1'b1);
      tick();
      mem_resp.Ready = 1'b0;
      chk("t2_grant_idle", grant, 2'b00);
    end

    // Busy hold
    ic_req.Valid = 1'b0;
    dc_req       = '{1'b1, 1'b0, 128'h0, 32'h200};
    tick();
    chk("t3_grant", grant, 2'b10);
    chk("t3_addr", mem_req.Addr, 32'h200);
    dc_req.Addr = 32'h300;
    ic_req      = '{1'b1, 1'b0, 128'h0, 32'h500};
    tick();
    chk("t3_addr_hold1", mem_req.Addr, 32'h200);
    chk("t3_grant_hold1", grant, 2'b10);
    tick();
    chk("t3_addr_hold2", mem_req.Addr, 32'h200);
    chk("t3_grant_hold2", grant, 2'b10);
    mem_resp.Ready = 1'b1;
    #1;
    chk("t3_dc_ready", dc_resp.Ready, 1'b1);
    chk("t3_ic_ready", ic_resp.Ready, 1'b0);
    tick();
    mem_resp.Ready = 1'b0;
    dc_req.Valid   = 1'b0;
    chk("t3_idle_grant", grant, 2'b00);
    chk("t3_idle_valid", mem_req.Valid, 1'b0);
    tick();
    chk("t3_ic_grant", grant, 2'b01);
    chk("t3_ic_addr", mem_req.Addr, 32'h500);
    mem_resp.Ready = 1'b1;
    tick();
    ic_req.Valid   = 1'b0;
    mem_resp.Ready = 1'b0;

    // Spurious Ready while idle
    mem_resp.Ready = 1'b1;
    #1;
    chk("t4_ic_ready", ic_resp.Ready, 1'b0);
    chk("t4_dc_ready", dc_resp.Ready, 1'b0);
    tick();
    mem_resp.Ready = 1'b0;
    chk("t4_grant", grant, 2'b00);
    chk("t4_valid", mem_req.Valid, 1'b0);
    ic_req = '{1'b1, 1'b0, 128'h0, 32'h600};
    tick();
    chk("t4_regrant", grant, 2'b01);
    chk("t4_addr", mem_req.Addr, 32'h600);
    mem_resp.Ready = 1'b1;
    tick();
    ic_req.Valid   = 1'b0;
    mem_resp.Ready = 1'b0;

    // Watchdog
    do_reset();
    ic_req = '{1'b1, 1'b0, 128'h0, 32'h700};
    tick();
    for (int k = 1; k < 8; k++) tick();
    chk("t5_before", timeout, 1'b0);
    tick();
    chk("t5_at8", timeout, 1'b1);
    mem_resp.Ready = 1'b1;
    tick();
    mem_resp.Ready = 1'b0;
    ic_req.Valid   = 1'b0;
    chk("t5_sticky", timeout, 1'b1);
    chk("t5_done_grant", grant, 2'b00);
    do_reset();
    chk("t5_cleared", timeout, 1'b0);
    ic_req = '{1'b1, 1'b0, 128'h0, 32'h700};
    tick();
    for (int k = 1; k < 8; k++) tick();
    mem_resp.Ready = 1'b1;
    #1;
    chk("t5_ready8_resp", ic_resp.Ready, 1'b1);
    tick();
    mem_resp.Ready = 1'b0;
    ic_req.Valid   = 1'b0;
    chk("t5_ready8_timeout", timeout, 1'b0);

    // Reset mid-transaction
    do_reset();
    ic_req = '{1'b1, 1'b0, 128'h0, 32'h800};
    dc_req = '{1'b1, 1'b1, 128'h1234, 32'h900};
    tick();
    chk("t6_grant", grant, 2'b01);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_valid", mem_req.Valid, 1'b0);
    chk("t6_grant_rst", grant, 2'b00);
    rst = 1'b0;
    tick();
    chk("t6_tie_ic", grant, 2'b01);
    chk("t6_addr", mem_req.Addr, 32'h800);
    mem_resp.Ready = 1'b1;
    tick();
    mem_resp.Ready = 1'b0;

    // Randomized traffic against the transaction-level model
    do_reset();
    m_busy = 1'b0;
    m_last = REQ_DC;
    m_own  = REQ_IC;
    m_exp  = '0;
    m_cnt  = 0;
    p_ic   = '0;
    p_dc   = '0;
    p_mr   = 1'b0;
    ic_got = 1'b0;
    dc_got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (!m_busy) begin
        if (p_ic.Valid || p_dc.Valid) begin
          if (p_ic.Valid && p_dc.Valid) m_own = (m_last == REQ_IC) ? REQ_DC : REQ_IC;
          else                          m_own = p_ic.Valid ? REQ_IC : REQ_DC;
          m_exp       = (m_own == REQ_IC) ? p_ic : p_dc;
          m_exp.Valid = 1'b1;
          m_last      = m_own;
          m_busy      = 1'b1;
          m_cnt       = $urandom_range(1, 5);
        end
      end else if (p_mr) begin
        m_busy = 1'b0;
      end
      chk("rnd_grant", grant, m_busy ? ((m_own == REQ_IC) ? 2'b01 : 2'b10) : 2'b00);
      chk("rnd_mem_req", mem_req, m_busy ? m_exp : '0);
      chk("rnd_timeout", timeout, 1'b0);

      if (ic_got) ic_req.Valid = 1'b0;
      else if (!ic_req.Valid && ($urandom_range(0, 1) == 1))
        ic_req = '{1'b1, 1'($urandom), {$urandom, $urandom, $urandom, $urandom}, $urandom};
      if (dc_got) dc_req.Valid = 1'b0;
      else if (!dc_req.Valid && ($urandom_range(0, 1) == 1))
        dc_req = '{1'b1, 1'($urandom), {$urandom, $urandom, $urandom, $urandom}, $urandom};

      mem_resp.Ready = 1'b0;
      mem_resp.ReadD = {$urandom, $urandom, $urandom, $urandom};
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) mem_resp.Ready = 1'b1;
      end
      #1;
      ic_got = m_busy && (m_own == REQ_IC) && mem_resp.Ready;
      dc_got = m_busy && (m_own == REQ_DC) && mem_resp.Ready;
      chk("rnd_ic_ready", ic_resp.Ready, ic_got);
      chk("rnd_dc_ready", dc_resp.Ready, dc_got);
      if (mem_resp.Ready) begin
        chk("rnd_ic_readd", ic_resp.ReadD, mem_resp.ReadD);
        chk("rnd_dc_readd", dc_resp.ReadD, mem_resp.ReadD);
      end
      p_ic = ic_req;
      p_dc = dc_req;
      p_mr = mem_resp.Ready;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter sharing the single main-memory port between the instruction cache and the data cache. Each cache presents an MInput request and receives an MOutput response. The arbiter grants one requester at a time, registers its request onto the memory port, and holds it until memory returns Ready. It then routes the response back to the owner and rotates priority (round-robin). It sits between the two caches and main memory in the memory subsystem.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles in BUSY without mem Ready before timeout_o sets; 0 disables the watchdog
CNT_W, 16, width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
ic_req_i  input  MInput  instruction-cache request (Valid, Wen, WriteD, Addr)
ic_resp_o  output  MOutput  instruction-cache response (Ready, ReadD)
dc_req_i  input  MInput  data-cache request
dc_resp_o  output  MOutput  data-cache response
mem_req_o  output  MInput  request to main memory, driven from registers
mem_resp_i  input  MOutput  main-memory response
grant_o  output  2  one-hot owner: bit0 = icache, bit1 = dcache; 00 when idle
timeout_o  output  1  sticky watchdog error flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - State is IDLE.
  - mem_req_o is all-zero (Valid=0).
  - grant_o=00, timeout_o=0, watchdog count=0.
  - last_owner=DC, so icache wins the first tie.
- Requester protocol:
  - A requester raises Valid and holds Wen/Addr/WriteD stable until it sees Ready=1 on its resp.
  - It deasserts Valid in the cycle after Ready.
  - The arbiter does not check stability. It latches the request fields at grant time only.
- States: IDLE, BUSY.
- IDLE:
  - Samples ic_req_i.Valid and dc_req_i.Valid.
  - Only one valid: grant it.
  - Both valid: grant the one not equal to last_owner.
  - On grant at edge N: latch that MInput into mem_req_o, set Valid=1, set owner and grant_o, set last_owner=owner, clear the counter, go to BUSY.
  - mem_req_o.Valid is therefore high from cycle N+1.
- BUSY:
  - mem_req_o is held constant.
  - Owner resp: Ready = mem_resp_i.Ready, combinational, same cycle.
  - Non-owner Ready=0.
  - ReadD = mem_resp_i.ReadD is broadcast to both resp ports; it is only meaningful with Ready.
  - On mem_resp_i.Ready=1 at edge M: clear mem_req_o (all-zero), set grant_o=00, go to IDLE.
  - A new grant can therefore occur at edge M+1, with the next memory Valid at M+2. This gives a minimum 1-cycle Valid gap between transactions.
- IDLE with mem_resp_i.Ready=1 (spurious): ignored. Both resp Ready=0 and there is no state change.
- A requester that drops Valid while BUSY and not yet answered: the transaction still completes. Ready is still pulsed to that port.
- A non-owner asserting Valid while BUSY: it waits. Because of rotation it is granted next, so there is no starvation; worst-case wait is one transaction.
- Watchdog (TIMEOUT_CYCLES > 0):
  - The counter increments each BUSY cycle without Ready, saturating at max.
  - When count == TIMEOUT_CYCLES, timeout_o sets and stays 1 until rst.
  - The transaction is not aborted.
  - Ready in the same cycle as the threshold wins: no timeout is flagged.
- Reset mid-transaction: rst overrides everything in that cycle. The outstanding transaction is abandoned, and memory is reset by the same rst.
- Simultaneous first requests after reset: icache granted.

Decomposition:
- mem_pkg additions:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e
  - typedef enum logic {REQ_IC, REQ_DC} req_id_e
  - MInput/MOutput are reused unchanged.
- One natural sub-module: mem_arb_rr_pick. It is combinational: inputs are two Valids and last_owner; outputs are grant valid and winner id. It isolates the priority logic for unit test.
- The FSM, request register and watchdog stay in mem_arbiter.

Test Plan:
1. Single read: after reset, ic Valid=1, Wen=0, Addr=0x0000_0100.
   - Expect at the next cycle: mem_req_o.Valid=1, Addr=0x100, grant_o=01.
   - Memory returns Ready with ReadD=0xDEADBEEF_00000000_11111111_22222222 after 3 cycles.
   - Expect ic_resp_o.Ready=1 that cycle with that ReadD, and dc_resp_o.Ready=0.
   - Expect mem_req_o.Valid=0 the cycle after.
2. Tie and rotation: ic and dc both Valid, with ic Addr=0x40 and dc Addr=0x80 (Wen=1, WriteD=0xA5..A5).
   - Expect the ic transaction first (Addr 0x40), then dc (Addr 0x80, Wen=1, WriteD intact).
   - Both stay continuously valid for 4 transactions: expect grant order ic, dc, ic, dc.
3. Busy hold: grant dc, then change dc Addr after the grant before Ready.
   - Expect mem_req_o.Addr to stay at the originally latched value.
   - Raise ic Valid during BUSY: expect no grant change until Ready, and ic granted at the edge after the IDLE cycle.
4. Spurious Ready: in IDLE with no requests, pulse mem_resp_i.Ready.
   - Expect both resp Ready=0, grant_o=00, and the state remaining IDLE.
5. Watchdog: TIMEOUT_CYCLES=8, grant ic, and withhold Ready.
   - Expect timeout_o=1 after 8 BUSY cycles, staying high after a later Ready.
   - After rst, expect timeout_o=0.
   - Repeat with Ready exactly at cycle 8: expect timeout_o to remain 0.
6. Reset mid-op: assert rst during BUSY.
   - Expect at the next cycle: mem_req_o.Valid=0, grant_o=00, state IDLE.
   - After rst drops, expect the first tie to go to ic.
